// File: rtl/vdg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : vdg_pkg                                              |
// | Description : Shared VDG mode codes and pixel-depth type, used by  |
// |               the pixel shifter and the colour-mapping logic.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package vdg_pkg;

   // VDG mode codes as presented on the mode bus
   localparam logic [3:0] MODE_CG4   = 4'b0001;
   localparam logic [3:0] MODE_CG4B  = 4'b0011;
   localparam logic [3:0] MODE_RG    = 4'b0010;
   localparam logic [3:0] MODE_RG2   = 4'b0100;
   localparam logic [3:0] MODE_ALPHA = 4'b1000;

   // Bits per pixel carried alongside each byte in the shifter
   typedef enum logic {
      BPP_1 = 1'b0,
      BPP_2 = 1'b1
   } bpp_t;

   // Only the colour-graphics codes are 2bpp; everything else,
   // including unlisted codes, falls back to 1bpp.
   function automatic bpp_t mode_to_bpp(input logic [3:0] mode);
      case (mode)
         MODE_CG4, MODE_CG4B: return BPP_2;
         default:             return BPP_1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pixel_shifter                                        |
// | Description : Two-stage (hold + shift) video byte serialiser that  |
// |               emits 1bpp or 2bpp colour codes per pixel slot, with |
// |               border handling, pixel repeat and underrun flag.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pixel_shifter
   import vdg_pkg::*;
#(
   parameter int PIX_REPEAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pixel_en,
   input  logic       active,
   input  logic [3:0] mode,
   input  logic       css,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_req,
   output logic [1:0] colour,
   output logic       screen,
   output logic       border,
   output logic       pixel_valid,
   output logic       underrun,
   input  logic       underrun_clr
);

   // Value of the repeat counter on the last slot of a pixel
   localparam logic [1:0] REP_LAST = 2'(PIX_REPEAT - 1);

   // Stored state
   logic [7:0] hold_q,       hold_d;
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] shift_q,      shift_d;
   logic [3:0] count_q,      count_d;
   logic [1:0] rep_q,        rep_d;
   bpp_t       bpp_q,        bpp_d;
   logic [1:0] colour_q,     colour_d;
   logic       screen_q,     screen_d;
   logic       border_q,     border_d;
   logic       pvalid_q;
   logic       underrun_q,   underrun_d;

   // Source of the pixel for this slot: either the running shift state
   // or, when the shifter is empty, the byte just pulled from hold.
   logic [7:0] w_src_byte;
   bpp_t       w_src_bpp;
   logic [3:0] w_src_count;
   logic [1:0] w_src_rep;

   // The hold buffer is the only source of back-pressure
   assign data_req = !hold_valid_q;

   // Next-state: byte accept, slot emission, border flush, underrun flag
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shift_d      = shift_q;
      count_d      = count_q;
      rep_d        = rep_q;
      bpp_d        = bpp_q;
      colour_d     = colour_q;
      screen_d     = screen_q;
      border_d     = border_q;
      underrun_d   = underrun_q;

      w_src_byte   = shift_q;
      w_src_bpp    = bpp_q;
      w_src_count  = count_q;
      w_src_rep    = rep_q;

      if (underrun_clr) begin
         underrun_d = 1'b0;
      end

      // Accept only while empty; a drain in this cycle cannot overlap
      // because a drain needs hold_valid_q already set.
      if (!hold_valid_q && data_valid) begin
         hold_d       = data_in;
         hold_valid_d = 1'b1;
      end

      if (pixel_en) begin
         screen_d = css;
         if (!active) begin
            // Border: flush partial byte, keep prefetched hold byte
            colour_d = 2'd0;
            border_d = 1'b1;
            count_d  = 4'd0;
            rep_d    = 2'd0;
         end else if (count_q == 4'd0 && !hold_valid_q) begin
            // Active pixel with nothing to show
            colour_d   = 2'd0;
            border_d   = 1'b0;
            underrun_d = 1'b1;
         end else begin
            if (count_q == 4'd0) begin
               // Drain hold into the shifter and use it in this same slot
               w_src_byte   = hold_q;
               w_src_bpp    = mode_to_bpp(mode);
               w_src_count  = (w_src_bpp == BPP_2) ? 4'd4 : 4'd8;
               w_src_rep    = 2'd0;
               hold_valid_d = 1'b0;
            end
            bpp_d    = w_src_bpp;
            border_d = 1'b0;
            colour_d = (w_src_bpp == BPP_2) ? w_src_byte[7:6]
                                            : {1'b0, w_src_byte[7]};
            if (w_src_rep == REP_LAST) begin
               shift_d = (w_src_bpp == BPP_2) ? {w_src_byte[5:0], 2'b00}
                                              : {w_src_byte[6:0], 1'b0};
               count_d = w_src_count - 4'd1;
               rep_d   = 2'd0;
            end else begin
               shift_d = w_src_byte;
               count_d = w_src_count;
               rep_d   = w_src_rep + 2'd1;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q       <= 8'd0;
         hold_valid_q <= 1'b0;
         shift_q      <= 8'd0;
         count_q      <= 4'd0;
         rep_q        <= 2'd0;
         bpp_q        <= BPP_1;
         colour_q     <= 2'd0;
         screen_q     <= 1'b0;
         border_q     <= 1'b1;
         pvalid_q     <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shift_q      <= shift_d;
         count_q      <= count_d;
         rep_q        <= rep_d;
         bpp_q        <= bpp_d;
         colour_q     <= colour_d;
         screen_q     <= screen_d;
         border_q     <= border_d;
         pvalid_q     <= pixel_en;
         underrun_q   <= underrun_d;
      end
   end

   assign colour      = colour_q;
   assign screen      = screen_q;
   assign border      = border_q;
   assign pixel_valid = pvalid_q;
   assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_pixel_shifter                                     |
// | Description : Directed self-checking bench for pixel_shifter,      |
// |               with a PIX_REPEAT=1 and a PIX_REPEAT=2 instance.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_pixel_shifter;

   logic       clk = 1'b0;
   logic       reset, pixel_en, active, css, data_valid, underrun_clr;
   logic [3:0] mode;
   logic [7:0] data_in;

   logic       data_req, screen, border, pixel_valid, underrun;
   logic [1:0] colour;
   logic       d2_data_req, d2_screen, d2_border, d2_pixel_valid, d2_underrun;
   logic [1:0] d2_colour;

   int checks = 0;
   int errors = 0;
   logic [7:0] feed_q[$];
   logic [1:0] exp_c[$];

   always #5 clk = ~clk;

   pixel_shifter #(.PIX_REPEAT(1)) u_dut (
      .clk(clk), .reset(reset), .pixel_en(pixel_en), .active(active),
      .mode(mode), .css(css), .data_in(data_in), .data_valid(data_valid),
      .data_req(data_req), .colour(colour), .screen(screen), .border(border),
      .pixel_valid(pixel_valid), .underrun(underrun), .underrun_clr(underrun_clr)
   );

   pixel_shifter #(.PIX_REPEAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .pixel_en(pixel_en), .active(active),
      .mode(mode), .css(css), .data_in(data_in), .data_valid(data_valid),
      .data_req(d2_data_req), .colour(d2_colour), .screen(d2_screen),
      .border(d2_border), .pixel_valid(d2_pixel_valid), .underrun(d2_underrun),
      .underrun_clr(underrun_clr)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock, offering the next queued byte whenever data_req is high
   task automatic feed_tick();
      if (data_req && feed_q.size() > 0) begin
         data_in    = feed_q.pop_front();
         data_valid = 1'b1;
      end else begin
         data_valid = 1'b0;
      end
      tick();
      data_valid = 1'b0;
   endtask

   // Border slot with underrun cleared: flush shifter, idle
   task automatic idle();
      active       = 1'b0;
      pixel_en     = 1'b1;
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      pixel_en     = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pixel_en = 1'b0; active = 1'b0; css = 1'b0;
      data_valid = 1'b0; underrun_clr = 1'b0; mode = 4'b0010; data_in = 8'h00;
      #1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("rst_colour", {6'd0, colour}, 8'd0);
      chk("rst_border", {7'd0, border}, 8'd1);
      chk("rst_pvalid", {7'd0, pixel_valid}, 8'd0);
      chk("rst_underrun", {7'd0, underrun}, 8'd0);
      chk("rst_data_req", {7'd0, data_req}, 8'd1);

      // PIX_REPEAT=2, mode 0001, 0xC0 -> 3,3,0,0,0,0,0,0
      mode = 4'b0001;
      feed_q.push_back(8'hC0);
      feed_tick();
      chk("rep2_data_req", {7'd0, d2_data_req}, 8'd0);
      exp_c = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("rep2_c%0d", i), {6'd0, d2_colour}, {6'd0, exp_c[i]});
      end
      chk("rep2_no_underrun", {7'd0, d2_underrun}, 8'd0);

      // 1bpp 0xB4 prefetched in border -> 1,0,1,1,0,1,0,0 then underrun
      reset = 1'b1; pixel_en = 1'b0; active = 1'b0;
      tick();
      reset = 1'b0;
      mode = 4'b0010;
      css  = 1'b1;
      feed_q.push_back(8'hB4);
      feed_tick();
      chk("b4_hold_full", {7'd0, data_req}, 8'd0);
      exp_c = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("b4_c%0d", i), {6'd0, colour}, {6'd0, exp_c[i]});
         chk($sformatf("b4_b%0d", i), {7'd0, border}, 8'd0);
      end
      chk("b4_pvalid", {7'd0, pixel_valid}, 8'd1);
      chk("b4_screen", {7'd0, screen}, 8'd1);
      chk("b4_pre_underrun", {7'd0, underrun}, 8'd0);
      tick();
      chk("b4_underrun", {7'd0, underrun}, 8'd1);
      chk("b4_ur_colour", {6'd0, colour}, 8'd0);
      chk("b4_ur_border", {7'd0, border}, 8'd0);
      pixel_en = 1'b0;
      tick();
      chk("b4_pvalid_low", {7'd0, pixel_valid}, 8'd0);
      chk("b4_sticky", {7'd0, underrun}, 8'd1);
      // clear and set in the same cycle: set wins
      pixel_en = 1'b1; underrun_clr = 1'b1;
      tick();
      chk("b4_set_wins", {7'd0, underrun}, 8'd1);
      pixel_en = 1'b0;
      tick();
      chk("b4_cleared", {7'd0, underrun}, 8'd0);
      underrun_clr = 1'b0;

      // 2bpp 0x1B then 0xE4 -> 0,1,2,3,3,2,1,0, no underrun
      css = 1'b0;
      idle();
      mode = 4'b0001;
      feed_q.push_back(8'h1B);
      feed_q.push_back(8'hE4);
      feed_tick();
      exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         feed_tick();
         chk($sformatf("cg4_c%0d", i), {6'd0, colour}, {6'd0, exp_c[i]});
      end
      chk("cg4_no_underrun", {7'd0, underrun}, 8'd0);

      // Mode 0001 -> 0010 mid-byte: 0x1B finishes 2bpp, 0xB4 is 1bpp
      idle();
      mode = 4'b0001;
      feed_q.push_back(8'h1B);
      feed_q.push_back(8'hB4);
      feed_tick();
      exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd1,
                2'd0, 2'd1, 2'd0, 2'd0};
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) mode = 4'b0010;
         feed_tick();
         chk($sformatf("msw_c%0d", i), {6'd0, colour}, {6'd0, exp_c[i]});
      end
      chk("msw_no_underrun", {7'd0, underrun}, 8'd0);

      // active drops after 3 pixels of 0xFF; restart from prefetched 0x55
      idle();
      mode = 4'b0010;
      feed_q.push_back(8'hFF);
      feed_q.push_back(8'h55);
      feed_tick();
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         feed_tick();
         chk($sformatf("brd_ff%0d", i), {6'd0, colour}, 8'd1);
      end
      active = 1'b0;
      feed_tick();
      chk("brd_border", {7'd0, border}, 8'd1);
      chk("brd_colour", {6'd0, colour}, 8'd0);
      chk("brd_prefetch_kept", {7'd0, data_req}, 8'd0);
      feed_tick();
      active = 1'b1;
      exp_c = '{2'd0, 2'd1, 2'd0, 2'd1};
      for (int i = 0; i < 4; i++) begin
         feed_tick();
         chk($sformatf("brd_re_c%0d", i), {6'd0, colour}, {6'd0, exp_c[i]});
         chk($sformatf("brd_re_b%0d", i), {7'd0, border}, 8'd0);
      end

      // data_valid while data_req=0 is ignored
      reset = 1'b1; pixel_en = 1'b0; active = 1'b0;
      tick();
      reset = 1'b0;
      mode = 4'b0010;
      feed_q.push_back(8'hFF);
      feed_tick();
      data_in = 8'h00; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      active = 1'b1; pixel_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("ign_c%0d", i), {6'd0, colour}, 8'd1);
      end
      tick();
      chk("ign_underrun", {7'd0, underrun}, 8'd1);

      // reset mid-line discards everything
      active = 1'b0; pixel_en = 1'b0;
      feed_q.push_back(8'hFF);
      feed_tick();
      active = 1'b1; pixel_en = 1'b1;
      tick();
      tick();
      chk("mid_c", {6'd0, colour}, 8'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0; pixel_en = 1'b0;
      tick();
      chk("mid_border", {7'd0, border}, 8'd1);
      chk("mid_data_req", {7'd0, data_req}, 8'd1);
      chk("mid_underrun", {7'd0, underrun}, 8'd0);
      chk("mid_colour", {6'd0, colour}, 8'd0);
      pixel_en = 1'b1;
      tick();
      chk("mid_no_partial", {6'd0, colour}, 8'd0);
      chk("mid_underrun2", {7'd0, underrun}, 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_shifter.md
PIXEL_SHIFTER -- requirements
Module: pixel_shifter

Interface
REQ-001 SHALL have parameter PIX_REPEAT, default 1, meaning pixel_en pulses each pixel is held (1..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pixel_en  input  1  one-cycle pixel-clock enable; one pixel slot per asserted cycle.
REQ-005 SHALL have port active  input  1  high in the active display area, low in the border, sampled on pixel_en.
REQ-006 SHALL have port mode  input  4  VDG mode code: 0001/0011 = 2bpp, 0010/0100/1000/others = 1bpp.
REQ-007 SHALL have port css  input  1  colour-set select, passed through to screen.
REQ-008 SHALL have port data_in  input  8  video byte, MSB = leftmost pixel.
REQ-009 SHALL have port data_valid  input  1  data_in is valid this cycle.
REQ-010 SHALL have port data_req  output  1  hold buffer empty; a byte is accepted this cycle if data_valid is high.
REQ-011 SHALL have port colour  output  2  pixel colour code for the colour mapper.
REQ-012 SHALL have port screen  output  1  registered css aligned with colour.
REQ-013 SHALL have port border  output  1  current pixel is border.
REQ-014 SHALL have port pixel_valid  output  1  colour/screen/border updated this cycle.
REQ-015 SHALL have port underrun  output  1  sticky flag: an active pixel found no data.
REQ-016 SHALL have port underrun_clr  input  1  clears underrun.

Function
REQ-017 SHALL hold one byte in hold_reg (with hold_valid) and one in shift_reg (with pixels-remaining count, repeat count and latched bpp).
REQ-018 SHALL drive data_req = !hold_valid combinationally from the register.
REQ-019 SHALL load hold_reg when data_req && data_valid; data_valid while !data_req SHALL be ignored.
REQ-020 SHALL latch bpp from mode when a byte moves into shift_reg; later mode changes SHALL NOT affect that byte.
REQ-021 On pixel_en && active with count 0 and hold_valid: SHALL move hold_reg to shift_reg, clear hold_valid and emit the first pixel in the same slot.
REQ-022 2bpp pixel SHALL be shift_reg[7:6] (4 per byte); 1bpp pixel SHALL be {1'b0, shift_reg[7]} (8 per byte).
REQ-023 Each pixel SHALL be emitted on PIX_REPEAT consecutive pixel_en slots before shifting by 1 or 2 bits.
REQ-024 On pixel_en && active with count 0 and !hold_valid: SHALL emit colour 0 and border 0, and set underrun.
REQ-025 On pixel_en && !active: SHALL emit colour 0 and border 1, and flush the shift state (count 0, repeat 0); hold_reg SHALL be retained for prefetch.
REQ-026 Outputs SHALL register on pixel_en: one-cycle latency. pixel_valid SHALL pulse for exactly the cycle after pixel_en. Outputs SHALL hold between pixel_en pulses.
REQ-027 A hold_reg drain and a new accept SHALL NOT occur in the same cycle; a byte arriving in the drain cycle SHALL wait until data_req reasserts next cycle.
REQ-028 When underrun_clr and a new underrun coincide, set SHALL win.

Reset
REQ-029 Reset SHALL set hold_valid=0, count=0, repeat=0, colour=0, screen=0, border=1, pixel_valid=0, underrun=0; data_req SHALL read 1 in the following cycle.
REQ-030 Reset asserted mid-byte SHALL discard hold and shift contents with no partial pixel emitted.

Structure
REQ-031 Mode code constants (MODE_CG4=0001, MODE_CG4B=0011, MODE_RG=0010, MODE_RG2=0100, MODE_ALPHA=1000) and a bpp_t enum SHALL live in the shared package vdg_pkg, also used by the colour-mapping logic.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Reset, prefetch 0xB4 in border, mode 0010, PIX_REPEAT 1, active with pixel_en every cycle -> colours 1,0,1,1,0,1,0,0, then underrun=1.
REQ-034 Mode 0001, bytes 0x1B then 0xE4 supplied on data_req -> colours 0,1,2,3,3,2,1,0 with no underrun.
REQ-035 PIX_REPEAT 2, mode 0001, 0xC0 -> colour 3,3,0,0,0,0,0,0 over 8 slots.
REQ-036 Mode switches 0001->0010 mid-byte -> current byte finishes as 2bpp and the next byte is 1bpp.
REQ-037 active drops after 3 pixels of 0xFF -> border=1 and colour 0; on reactivation the first pixel comes from the prefetched byte.
REQ-038 data_valid with data_req=0 -> byte ignored; reset mid-line -> border=1, data_req=1, underrun=0.
